alu: RTL and testbench

//   32-bit integer ALU with a registered result stage. A and B are combined per a 7-bit opcode.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_shifter.sv | 42 ++++
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, flag bit positions,
// shifter mode encoding and the signed-overflow helpers.
package alu_pkg;

   localparam int WIDTH  = 32;
   localparam int OPW    = 7;
   localparam int NFLAGS = 5;

   typedef logic [OPW-1:0] opcode_t;

   localparam opcode_t OP_ADD   = 7'h00;
   localparam opcode_t OP_SUB   = 7'h01;
   localparam opcode_t OP_AND   = 7'h02;
   localparam opcode_t OP_OR    = 7'h03;
   localparam opcode_t OP_XOR   = 7'h04;
   localparam opcode_t OP_NOR   = 7'h05;
   localparam opcode_t OP_SLL   = 7'h06;
   localparam opcode_t OP_SRL   = 7'h07;
   localparam opcode_t OP_SRA   = 7'h08;
   localparam opcode_t OP_SLT   = 7'h09;
   localparam opcode_t OP_SLTU  = 7'h0A;
   localparam opcode_t OP_PASSA = 7'h0B;
   localparam opcode_t OP_PASSB = 7'h0C;
   localparam opcode_t OP_NOT   = 7'h0D;
   localparam opcode_t OP_INC   = 7'h0E;
   localparam opcode_t OP_DEC   = 7'h0F;

   // Status vector layout {N,Z,C,V,ILL}
   localparam int FLG_N   = 4;
   localparam int FLG_Z   = 3;
   localparam int FLG_C   = 2;
   localparam int FLG_V   = 1;
   localparam int FLG_ILL = 0;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_mode_e;

   // Addition overflows when both operands share a sign the result lacks.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   // Subtraction overflows when operand signs differ and the result leaves A's sign.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb != b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: one right shifter serves all three modes; left
// shifts are done by bit-reversing the operand before and after.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int W  = WIDTH,
   parameter int SW = $clog2(W)
)(
   input  logic [W-1:0]  a,
   input  logic [SW-1:0] shamt,
   input  shift_mode_e   mode,
   output logic [W-1:0]  result,
   output logic          shout
);

   logic [W-1:0] a_rev;
   logic [W-1:0] core_res;
   logic [W-1:0] res_rev;
   logic [W:0]   core_in;
   logic [W:0]   core_out;
   logic [W:0]   fill_mask;
   logic         fill;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_rev
         assign a_rev[gi]   = a[W-1-gi];
         assign res_rev[gi] = core_res[W-1-gi];
      end
   endgenerate

   // A guard bit below the operand catches the last bit shifted out; for a
   // zero shift it stays 0, which is exactly the required carry.
   assign core_in   = (mode == SH_SLL) ? {a_rev, 1'b0} : {a, 1'b0};
   assign fill      = (mode == SH_SRA) ? a[W-1] : 1'b0;
   assign fill_mask = ~({(W+1){1'b1}} >> shamt);
   assign core_out  = (core_in >> shamt) | (fill ? fill_mask : '0);

   assign core_res  = core_out[W:1];
   assign shout     = core_out[0];
   assign result    = (mode == SH_SLL) ? res_rev : core_res;

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU: combinational op mux and flag logic feeding a single
// output register bank, giving a fixed one-cycle latency.
module alu #(
   parameter int WIDTH = alu_pkg::WIDTH
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          A,
   input  logic [WIDTH-1:0]          B,
   input  logic [alu_pkg::OPW-1:0]   opcode,
   output logic [WIDTH-1:0]          aluOut,
   output logic                      carry,
   output logic [alu_pkg::NFLAGS-1:0] flags
);
   import alu_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0]  rhs;
   logic [WIDTH:0]    sum_ext;
   logic [WIDTH:0]    diff_ext;
   logic [WIDTH-1:0]  sh_res;
   logic              sh_out;
   shift_mode_e       sh_mode;

   logic [WIDTH-1:0]  res_next;
   logic              c_next;
   logic              v_next;
   logic              ill_next;
   logic [NFLAGS-1:0] flags_next;

   logic [WIDTH-1:0]  alu_out_reg;
   logic [NFLAGS-1:0] flags_reg;

   // INC/DEC reuse the A+B / A-B datapath with a constant 1 operand.
   assign rhs      = (opcode == OP_INC || opcode == OP_DEC) ? WIDTH'(1) : B;
   assign sum_ext  = {1'b0, A} + {1'b0, rhs};
   assign diff_ext = {1'b0, A} - {1'b0, rhs};

   always_comb begin
      sh_mode = SH_SRA;
      case (opcode)
         OP_SLL:  sh_mode = SH_SLL;
         OP_SRL:  sh_mode = SH_SRL;
         default: sh_mode = SH_SRA;
      endcase
   end

   alu_shifter #(
      .W  (WIDTH),
      .SW (SHW)
   ) u_shifter (
      .a      (A),
      .shamt  (B[SHW-1:0]),
      .mode   (sh_mode),
      .result (sh_res),
      .shout  (sh_out)
   );

   always_comb begin
      res_next = '0;
      c_next   = 1'b0;
      v_next   = 1'b0;
      ill_next = 1'b0;
      case (opcode)
         OP_ADD, OP_INC: begin
            res_next = sum_ext[WIDTH-1:0];
            c_next   = sum_ext[WIDTH];
            v_next   = add_ovf(A[WIDTH-1], rhs[WIDTH-1], sum_ext[WIDTH-1]);
         end
         // Carry means "no borrow", i.e. A >= operand unsigned.
         OP_SUB, OP_DEC: begin
            res_next = diff_ext[WIDTH-1:0];
            c_next   = ~diff_ext[WIDTH];
            v_next   = sub_ovf(A[WIDTH-1], rhs[WIDTH-1], diff_ext[WIDTH-1]);
         end
         OP_AND:   res_next = A & B;
         OP_OR:    res_next = A | B;
         OP_XOR:   res_next = A ^ B;
         OP_NOR:   res_next = ~(A | B);
         OP_SLL, OP_SRL, OP_SRA: begin
            res_next = sh_res;
            c_next   = sh_out;
         end
         OP_SLT:   res_next = WIDTH'($signed(A) < $signed(B));
         OP_SLTU:  res_next = WIDTH'(A < B);
         OP_PASSA: res_next = A;
         OP_PASSB: res_next = B;
         OP_NOT:   res_next = ~A;
         default:  ill_next = 1'b1;
      endcase
   end

   always_comb begin
      flags_next          = '0;
      flags_next[FLG_N]   = res_next[WIDTH-1];
      flags_next[FLG_Z]   = (res_next == '0);
      flags_next[FLG_C]   = c_next;
      flags_next[FLG_V]   = v_next;
      flags_next[FLG_ILL] = ill_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_reg <= '0;
         flags_reg   <= '0;
      end else begin
         alu_out_reg <= res_next;
         flags_reg   <= flags_next;
      end
   end

   assign aluOut = alu_out_reg;
   assign flags  = flags_reg;
   assign carry  = flags_reg[FLG_C];

endmodule

// File: tb/tb_alu.sv
// Directed vectors with hand-computed results, asynchronous reset checks and an
// opcode sweep scored against an independent reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [6:0]  opcode;
   logic [31:0] aluOut;
   logic        carry;
   logic [4:0]  flags;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  op;
      logic [31:0] out;
      logic [4:0]  flg;
   } vec_t;

   typedef struct packed {
      logic [31:0] r;
      logic [4:0]  f;
   } res_t;

   localparam longint MAXI = 64'sd2147483647;
   localparam longint MINI = -64'sd2147483648;

   vec_t vq[$];
   res_t sb_q[$];

   alu dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .opcode (opcode),
      .aluOut (aluOut),
      .carry  (carry),
      .flags  (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: bitwise loops for shifts, wide signed arithmetic for overflow.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op);
      res_t        m;
      longint      sa;
      longint      sb;
      longint      sr;
      logic [32:0] u;
      logic [31:0] r;
      logic        c;
      logic        v;
      logic        ill;
      int          sh;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sh  = int'(b[4:0]);
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      ill = 1'b0;
      case (op)
         7'h00: begin
            u = {1'b0, a} + {1'b0, b}; r = u[31:0]; c = u[32];
            sr = sa + sb; v = (sr > MAXI) || (sr < MINI);
         end
         7'h01: begin
            r = a - b; c = (a >= b);
            sr = sa - sb; v = (sr > MAXI) || (sr < MINI);
         end
         7'h02: r = a & b;
         7'h03: r = a | b;
         7'h04: r = a ^ b;
         7'h05: r = ~(a | b);
         7'h06: begin
            r = a;
            for (int i = 0; i < sh; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end
         end
         7'h07: begin
            r = a;
            for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[31:1]}; end
         end
         7'h08: begin
            r = a;
            for (int i = 0; i < sh; i++) begin c = r[0]; r = {r[31], r[31:1]}; end
         end
         7'h09: r = (sa < sb) ? 32'd1 : 32'd0;
         7'h0A: r = (a < b) ? 32'd1 : 32'd0;
         7'h0B: r = a;
         7'h0C: r = b;
         7'h0D: r = ~a;
         7'h0E: begin
            r = a + 32'd1; c = (a == 32'hFFFF_FFFF);
            sr = sa + 1; v = (sr > MAXI) || (sr < MINI);
         end
         7'h0F: begin
            r = a - 32'd1; c = (a != 32'd0);
            sr = sa - 1; v = (sr > MAXI) || (sr < MINI);
         end
         default: ill = 1'b1;
      endcase
      m.r = r;
      m.f = {r[31], (r == 32'd0), c, v, ill};
      return m;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      res_t e;
      rst_n  = 1'b1;
      A      = '0;
      B      = '0;
      opcode = '0;

      // Power-up reset
      #1 rst_n = 1'b0;
      #2;
      chk("rst0_out",   aluOut, 32'd0);
      chk("rst0_flags", 32'(flags), 32'd0);
      chk("rst0_carry", 32'(carry), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      vq.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 7'h00, 32'h0000_0000, 5'b01100});
      vq.push_back('{32'h8000_0000, 32'h0000_0001, 7'h01, 32'h7FFF_FFFF, 5'b00110});
      vq.push_back('{32'h8000_0001, 32'h0000_0001, 7'h08, 32'hC000_0000, 5'b10100});
      vq.push_back('{32'h8000_0001, 32'h0000_0000, 7'h08, 32'h8000_0001, 5'b10000});
      vq.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 7'h7F, 32'h0000_0000, 5'b01001});
      vq.push_back('{32'h0000_0003, 32'h0000_001F, 7'h06, 32'h8000_0000, 5'b10100});
      vq.push_back('{32'h0000_0000, 32'h0000_0000, 7'h0F, 32'hFFFF_FFFF, 5'b10000});
      vq.push_back('{32'h7FFF_FFFF, 32'h0000_0000, 7'h0E, 32'h8000_0000, 5'b10010});
      vq.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 7'h09, 32'h0000_0001, 5'b00000});
      vq.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 7'h0A, 32'h0000_0000, 5'b01000});
      vq.push_back('{32'h0000_0000, 32'h0000_0000, 7'h05, 32'hFFFF_FFFF, 5'b10000});

      // Directed vectors: drive on the falling edge, check one cycle later
      foreach (vq[i]) begin
         v = vq[i];
         A = v.a; B = v.b; opcode = v.op;
         @(negedge clk);
         $display("txn dir op=%h a=%h b=%h out=%h carry=%b flags=%b", v.op, v.a, v.b, aluOut, carry, flags);
         chk("dir_out",   aluOut, v.out);
         chk("dir_flags", 32'(flags), 32'(v.flg));
         chk("dir_carry", 32'(carry), 32'(v.flg[2]));
      end

      // Asynchronous reset mid-run, away from any clock edge
      A = 32'd1; B = 32'd1; opcode = 7'h00;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out",   aluOut, 32'd0);
      chk("arst_flags", 32'(flags), 32'd0);
      chk("arst_carry", 32'(carry), 32'd0);
      @(negedge clk);
      chk("arst_hold_out", aluOut, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      $display("txn post_reset op=00 a=1 b=1 out=%h flags=%b", aluOut, flags);
      chk("post_rst_out",   aluOut, 32'd2);
      chk("post_rst_flags", 32'(flags), 32'd0);

      // Opcode sweep with a one-deep scoreboard
      for (int k = 0; k <= 128; k++) begin
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("txn sweep op=%h out=%h carry=%b flags=%b", 7'(k - 1), aluOut, carry, flags);
            chk("sw_out",   aluOut, e.r);
            chk("sw_flags", 32'(flags), 32'(e.f));
            chk("sw_c_f2",  32'(carry), 32'(flags[2]));
         end
         if (k < 128) begin
            A      = $urandom;
            B      = $urandom;
            opcode = 7'(k);
            sb_q.push_back(model(A, B, opcode));
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
